// File: rtl/part_hist_v2_pkg.sv
// part_hist_v2 shared types and constants.
// State encoding, output field widths, run-length helper.
package part_hist_v2_pkg;

  typedef enum logic [2:0] {
    INIT_CLR,
    IDLE,
    ACCUM,
    DRAIN,
    EMIT,
    CLEAR,
    DONE
  } state_t;

  localparam int MODE_LANE_W = 4;
  localparam int MODE_BIN_W  = 12;
  localparam int OUT_W       = 16;
  localparam int LANE_SLOTS  = 2 ** MODE_LANE_W;

  // A zero run length still closes after one event.
  function automatic logic [31:0] run_len(
    input logic [31:0] acc
  );
    return (acc == '0) ? 32'd1 : acc;
  endfunction

endpackage

// File: rtl/part_hist_v2_if.sv
// part_hist_v2 bus: control handshake, input stream,
// both output FIFO ports and the dropped-event count.
interface part_hist_v2_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16
);
  import part_hist_v2_pkg::*;

  logic                       ap_start;
  logic                       ap_done;
  logic                       ap_idle;
  logic                       ap_ready;
  logic [NUM_CH*SAMPLE_W-1:0] data_in_V;
  logic                       input_valid_V;
  logic [31:0]                accumulation_V;
  logic [OUT_W-1:0]           frequency_out_V_V_din;
  logic                       frequency_out_V_V_full_n;
  logic                       frequency_out_V_V_write;
  logic [OUT_W-1:0]           mode_out_V_V_din;
  logic                       mode_out_V_V_full_n;
  logic                       mode_out_V_V_write;
  logic [15:0]                dropped_cnt;

  modport master (
    output ap_start,
    output data_in_V,
    output input_valid_V,
    output accumulation_V,
    output frequency_out_V_V_full_n,
    output mode_out_V_V_full_n,
    input  ap_done,
    input  ap_idle,
    input  ap_ready,
    input  frequency_out_V_V_din,
    input  frequency_out_V_V_write,
    input  mode_out_V_V_din,
    input  mode_out_V_V_write,
    input  dropped_cnt
  );

  modport slave (
    input  ap_start,
    input  data_in_V,
    input  input_valid_V,
    input  accumulation_V,
    input  frequency_out_V_V_full_n,
    input  mode_out_V_V_full_n,
    output ap_done,
    output ap_idle,
    output ap_ready,
    output frequency_out_V_V_din,
    output frequency_out_V_V_write,
    output mode_out_V_V_din,
    output mode_out_V_V_write,
    output dropped_cnt
  );

endinterface

// File: rtl/part_hist_v2_lane.sv
// One histogram lane: bin RAM with a read/modify/write pipe,
// in-flight forwarding, saturating counts and running mode.
module part_hist_lane #(
  parameter int BIN_BITS = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ev_vld,
  input  logic [BIN_BITS-1:0] ev_bin,
  input  logic                clr_en,
  input  logic [BIN_BITS-1:0] clr_addr,
  output logic [CNT_W-1:0]    max_cnt,
  output logic [BIN_BITS-1:0] mode_bin
);

  logic [CNT_W-1:0]    mem [2**BIN_BITS];
  logic [CNT_W-1:0]    rd_q;
  logic                s1_vld;
  logic [BIN_BITS-1:0] s1_bin;
  logic                s2_vld;
  logic [BIN_BITS-1:0] s2_bin;
  logic [CNT_W-1:0]    s2_cnt;
  logic [CNT_W-1:0]    old_cnt;
  logic [CNT_W-1:0]    new_cnt;

  // Pick the write still landing in RAM over the stale read.
  always_comb begin
    old_cnt = rd_q;
    if (s2_vld && s2_bin == s1_bin)
      old_cnt = s2_cnt;
    new_cnt = (&old_cnt) ? old_cnt : old_cnt + CNT_W'(1);
  end

  // 1R1W RAM: read on the event cycle, write one cycle later.
  always_ff @(posedge clk) begin
    rd_q <= mem[ev_bin];
    if (clr_en)
      mem[clr_addr] <= '0;
    else if (s1_vld)
      mem[s1_bin] <= new_cnt;
  end

  // Pipe stages plus the strict-greater mode tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_bin   <= '0;
      s2_vld   <= 1'b0;
      s2_bin   <= '0;
      s2_cnt   <= '0;
      max_cnt  <= '0;
      mode_bin <= '0;
    end else begin
      s1_vld <= ev_vld;
      s1_bin <= ev_bin;
      s2_vld <= s1_vld;
      s2_bin <= s1_bin;
      s2_cnt <= new_cnt;
      if (clr_en) begin
        max_cnt  <= '0;
        mode_bin <= '0;
      end else if (s1_vld && new_cnt > max_cnt) begin
        max_cnt  <= new_cnt;
        mode_bin <= s1_bin;
      end
    end
  end

endmodule

// File: rtl/part_hist_v2.sv
// part_hist_v2 top: run FSM, event and clear counters,
// per-lane emit into the two output FIFOs, dropped counter.
module part_hist_v2
  import part_hist_v2_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int BIN_BITS = 8,
  parameter int CNT_W    = 16
) (
  input logic           ap_clk,
  input logic           ap_rst,
  part_hist_v2_if.slave bus
);

  localparam logic [MODE_LANE_W-1:0] LAST =
    MODE_LANE_W'(NUM_CH - 1);

  state_t                 state;
  logic [BIN_BITS-1:0]    clr_addr;
  logic                   clr_en;
  logic                   ev_vld;
  logic [31:0]            ev_cnt;
  logic [31:0]            target;
  logic                   drain_q;
  logic [MODE_LANE_W-1:0] lane;
  logic                   done_q;
  logic                   idle_q;
  logic                   wr_q;
  logic [OUT_W-1:0]       freq_q;
  logic [OUT_W-1:0]       mode_q;
  logic [15:0]            dropped;
  logic                   fifo_ok;

  logic [CNT_W-1:0]    lmax  [LANE_SLOTS];
  logic [BIN_BITS-1:0] lmode [LANE_SLOTS];

  assign clr_en  = (state == INIT_CLR) || (state == CLEAR);
  assign ev_vld  = (state == ACCUM) && bus.input_valid_V;
  assign fifo_ok = bus.frequency_out_V_V_full_n &&
                   bus.mode_out_V_V_full_n;

  for (genvar c = 0; c < LANE_SLOTS; c++) begin : g_lane
    if (c < NUM_CH) begin : g_on
      part_hist_lane #(
        .BIN_BITS (BIN_BITS),
        .CNT_W    (CNT_W)
      ) u_lane (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .ev_vld   (ev_vld),
        .ev_bin   (bus.data_in_V[c*SAMPLE_W+SAMPLE_W-1 -: BIN_BITS]),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .max_cnt  (lmax[c]),
        .mode_bin (lmode[c])
      );
    end else begin : g_off
      assign lmax[c]  = '0;
      assign lmode[c] = '0;
    end
  end

  // Run sequencing with registered status and FIFO outputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= INIT_CLR;
      clr_addr <= '0;
      ev_cnt   <= '0;
      target   <= 32'd1;
      drain_q  <= 1'b0;
      lane     <= '0;
      done_q   <= 1'b0;
      idle_q   <= 1'b0;
      wr_q     <= 1'b0;
      freq_q   <= '0;
      mode_q   <= '0;
    end else begin
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      unique case (state)
        INIT_CLR, CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) begin
            if (state == INIT_CLR) begin
              state  <= IDLE;
              idle_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (bus.ap_start) begin
            state  <= ACCUM;
            idle_q <= 1'b0;
            target <= run_len(bus.accumulation_V);
            ev_cnt <= '0;
          end
        end
        ACCUM: begin
          drain_q <= 1'b0;
          if (bus.input_valid_V) begin
            ev_cnt <= ev_cnt + 32'd1;
            if (ev_cnt + 32'd1 == target)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state <= EMIT;
            lane  <= '0;
          end
        end
        EMIT: begin
          if (fifo_ok) begin
            wr_q   <= 1'b1;
            freq_q <= OUT_W'(lmax[lane]);
            mode_q <= {lane, MODE_BIN_W'(lmode[lane])};
            lane   <= lane + 1'b1;
            if (lane == LAST)
              state <= CLEAR;
          end
        end
        DONE: begin
          if (bus.ap_start) begin
            state  <= ACCUM;
            target <= run_len(bus.accumulation_V);
            ev_cnt <= '0;
          end else begin
            state  <= IDLE;
            idle_q <= 1'b1;
          end
        end
        default: state <= INIT_CLR;
      endcase
    end
  end

  // Count events that arrive while no run is accepting them.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)
      dropped <= '0;
    else if (bus.input_valid_V && state != ACCUM &&
             dropped != 16'hFFFF)
      dropped <= dropped + 16'd1;
  end

  assign bus.ap_done                 = done_q;
  assign bus.ap_ready                = done_q;
  assign bus.ap_idle                 = idle_q;
  assign bus.frequency_out_V_V_din   = freq_q;
  assign bus.frequency_out_V_V_write = wr_q;
  assign bus.mode_out_V_V_din        = mode_q;
  assign bus.mode_out_V_V_write      = wr_q;
  assign bus.dropped_cnt             = dropped;

endmodule

// File: tb/tb_part_hist_v2.sv
// Directed bench for part_hist_v2: main 16-bit-count instance
// plus a 4-bit-count instance for saturation.
module tb_part_hist_v2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  part_hist_v2_if #(.NUM_CH(4), .SAMPLE_W(16)) bus ();
  part_hist_v2_if #(.NUM_CH(4), .SAMPLE_W(16)) bus4 ();

  part_hist_v2 #(
    .NUM_CH(4), .SAMPLE_W(16), .BIN_BITS(8), .CNT_W(16)
  ) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  part_hist_v2 #(
    .NUM_CH(4), .SAMPLE_W(16), .BIN_BITS(8), .CNT_W(4)
  ) dut4 (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] fq[$];
  logic [15:0] md[$];
  int          wcyc[$];
  logic [15:0] fq4[$];
  logic [15:0] md4[$];
  bit          thr = 1'b0;
  int          bad_wr = 0;
  int          mis_wr = 0;
  int          last_ev = 0;

  // FIFO-side capture of every write strobe.
  always @(negedge clk) begin
    if (bus.frequency_out_V_V_write !=
        bus.mode_out_V_V_write)
      mis_wr++;
    if (bus.frequency_out_V_V_write) begin
      fq.push_back(bus.frequency_out_V_V_din);
      md.push_back(bus.mode_out_V_V_din);
      wcyc.push_back(cyc);
      if (thr) bad_wr++;
    end
    if (bus4.frequency_out_V_V_write) begin
      fq4.push_back(bus4.frequency_out_V_V_din);
      md4.push_back(bus4.mode_out_V_V_din);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] qget(
    input logic [15:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 16'hDEAD;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [31:0] acc);
    bus.accumulation_V = acc;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d);
    last_ev = cyc;
    bus.data_in_V = d;
    bus.input_valid_V = 1'b1;
    tick();
    bus.input_valid_V = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.ap_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (bus.ap_idle && bus4.ap_idle) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic clr_q();
    fq.delete();
    md.delete();
    wcyc.delete();
  endtask

  initial begin
    bus.ap_start = 1'b0;
    bus.data_in_V = '0;
    bus.input_valid_V = 1'b0;
    bus.accumulation_V = '0;
    bus.frequency_out_V_V_full_n = 1'b1;
    bus.mode_out_V_V_full_n = 1'b1;
    bus4.ap_start = 1'b0;
    bus4.data_in_V = '0;
    bus4.input_valid_V = 1'b0;
    bus4.accumulation_V = '0;
    bus4.frequency_out_V_V_full_n = 1'b1;
    bus4.mode_out_V_V_full_n = 1'b1;

    // reset and initial clear
    tick(100);
    chk("rst_idle", 32'(bus.ap_idle), 32'd0);
    chk("rst_done", 32'(bus.ap_done), 32'd0);
    chk("rst_drop", 32'(bus.dropped_cnt), 32'd0);
    rst = 1'b0;
    tick(255);
    chk("clr_255_idle", 32'(bus.ap_idle), 32'd0);
    tick();
    chk("clr_256_idle", 32'(bus.ap_idle), 32'd1);
    chk("init_writes", 32'(fq.size()), 32'd0);
    chk("init_drop", 32'(bus.dropped_cnt), 32'd0);

    // 12 events, one bin per lane
    clr_q();
    start_run(32'd12);
    chk("accum_idle", 32'(bus.ap_idle), 32'd0);
    for (int i = 0; i < 12; i++) begin
      send(64'h0800_0700_0600_0500);
      tick();
    end
    wait_done("b_done");
    chk("b_ready", 32'(bus.ap_ready), 32'd1);
    chk("b_nwr", 32'(fq.size()), 32'd4);
    chk("b_lat", 32'(wcyc.size() > 0 &&
        wcyc[0] - last_ev >= 3 &&
        wcyc[0] - last_ev <= 4), 32'd1);
    chk("b_f0", 32'(qget(fq, 0)), 32'd12);
    chk("b_f3", 32'(qget(fq, 3)), 32'd12);
    chk("b_m0", 32'(qget(md, 0)), 32'h0005);
    chk("b_m1", 32'(qget(md, 1)), 32'h1006);
    chk("b_m2", 32'(qget(md, 2)), 32'h2007);
    chk("b_m3", 32'(qget(md, 3)), 32'h3008);
    tick();
    chk("b_done_pulse", 32'(bus.ap_done), 32'd0);
    chk("b_back_idle", 32'(bus.ap_idle), 32'd1);

    // back-to-back events on one bin
    clr_q();
    start_run(32'd3);
    for (int i = 0; i < 3; i++) send(64'h0000_0000_0000_2200);
    wait_done("c_done");
    chk("c_f0", 32'(qget(fq, 0)), 32'd3);
    chk("c_m0", 32'(qget(md, 0)), 32'h0022);
    chk("c_f1", 32'(qget(fq, 1)), 32'd3);
    chk("c_m1", 32'(qget(md, 1)), 32'h1000);
    tick();

    // tie: first bin to reach the max wins
    clr_q();
    start_run(32'd4);
    send(64'h0000_0000_0000_0700);
    send(64'h0000_0000_0000_0700);
    send(64'h0000_0000_0000_0300);
    send(64'h0000_0000_0000_0300);
    wait_done("d_done");
    chk("d_f0", 32'(qget(fq, 0)), 32'd2);
    chk("d_m0", 32'(qget(md, 0)), 32'h0007);
    chk("d_f2", 32'(qget(fq, 2)), 32'd4);
    tick();

    // mode FIFO back-pressure across EMIT
    clr_q();
    chk("e_drop0", 32'(bus.dropped_cnt), 32'd0);
    start_run(32'd2);
    send(64'h0000_0000_0000_0100);
    bus.mode_out_V_V_full_n = 1'b0;
    thr = 1'b1;
    send(64'h0000_0000_0000_0100);
    tick(14);
    chk("e_hold_wr", 32'(bad_wr), 32'd0);
    chk("e_hold_n", 32'(fq.size()), 32'd0);
    bus.mode_out_V_V_full_n = 1'b1;
    thr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fq.size() >= 4) break;
      tick();
    end
    // lands in the first CLEAR cycle
    bus.input_valid_V = 1'b1;
    tick();
    bus.input_valid_V = 1'b0;
    wait_done("e_done");
    chk("e_nwr", 32'(fq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("e_lane", 32'(qget(md, i) >> 12), 32'(i));
    chk("e_f0", 32'(qget(fq, 0)), 32'd2);
    chk("e_drop1", 32'(bus.dropped_cnt), 32'd1);
    tick();

    // saturation with 4-bit counts
    bus4.accumulation_V = 32'd20;
    bus4.ap_start = 1'b1;
    tick();
    bus4.ap_start = 1'b0;
    bus4.input_valid_V = 1'b1;
    tick(20);
    bus4.input_valid_V = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if (bus4.ap_done) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      chk("g_done", 32'(seen), 32'd1);
    end
    chk("g_nwr", 32'(fq4.size()), 32'd4);
    chk("g_f0", 32'(qget(fq4, 0)), 32'd15);
    chk("g_f3", 32'(qget(fq4, 3)), 32'd15);
    chk("g_m3", 32'(qget(md4, 3)), 32'h3000);
    tick();

    // reset in the middle of ACCUM
    clr_q();
    start_run(32'd10);
    for (int i = 0; i < 3; i++) send(64'h0000_0000_0000_0900);
    rst = 1'b1;
    #1;
    chk("h_drop", 32'(bus.dropped_cnt), 32'd0);
    chk("h_idle", 32'(bus.ap_idle), 32'd0);
    chk("h_wr", 32'(bus.frequency_out_V_V_write), 32'd0);
    tick(5);
    rst = 1'b0;
    wait_idle("h_idle_back");
    chk("h_nwr0", 32'(fq.size()), 32'd0);
    start_run(32'd2);
    send(64'h0000_0000_0000_0900);
    send(64'h0000_0000_0000_0900);
    wait_done("h_done");
    chk("h_nwr", 32'(fq.size()), 32'd4);
    chk("h_f0", 32'(qget(fq, 0)), 32'd2);
    chk("h_m0", 32'(qget(md, 0)), 32'h0009);
    chk("strobe_pair", 32'(mis_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
